// File: rtl/syn_md_sched.sv
// syn_md_sched: burst scheduler for the sync-marker pulse stretcher.
// On a start request it issues num_pulse single-cycle triggers on
// syn_md_out_en, spaced by max(period, MIN_GAP) cycles. It then waits out the
// stretcher window before reporting done.
// Optional feature macro: SYN_SCHED_EXT_TRIG_EN. When it is defined, every
// pulse after the first also waits for a synchronised rising edge on ext_trig.
//
// Handshake: start is a level request. It is taken on a clkin edge only while
// the block is idle (busy=0) and abort=0. The burst configuration (period,
// num_pulse) is captured at that same edge. abort is honoured on any edge
// while busy=1. done and aborted are single-cycle status pulses.
module syn_md_sched #(
  parameter int CNT_W   = 16,
  parameter int NUM_W   = 8,
  parameter int MIN_GAP = 17
) (
  input  logic             clkin,
  input  logic             rst_n,
`ifdef SYN_SCHED_EXT_TRIG_EN
  input  logic             ext_trig,
`endif
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] period,
  input  logic [NUM_W-1:0] num_pulse,
  output logic             syn_md_out_en,
  output logic [NUM_W-1:0] pulse_idx,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_MIN_GAP = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ZERO    = '0;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_per_l;
  logic [NUM_W-1:0] r_num_l;
  logic [NUM_W-1:0] r_idx;
  logic             r_en;
  logic             r_done;
  logic             r_aborted;

  logic [CNT_W-1:0] w_per_clamp;
  logic [NUM_W-1:0] w_idx_inc;
  logic             w_trig_ok;

  // Spacing below the stretcher window would merge pulses, so clamp it.
  assign w_per_clamp = (period < C_MIN_GAP) ? C_MIN_GAP : period;
  assign w_idx_inc   = r_idx + NUM_W'(1);

`ifdef SYN_SCHED_EXT_TRIG_EN
  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  // Two-flop synchroniser plus a delay stage for rising-edge detection.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= ext_trig;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // An edge is only useful while WAIT sits at an expired timer; earlier edges are dropped.
  assign w_trig_ok = r_sync2 & ~r_sync3;
`else
  assign w_trig_ok = 1'b1;
`endif

  // Main scheduler FSM with registered status outputs.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= C_ZERO;
      r_per_l   <= C_ZERO;
      r_num_l   <= '0;
      r_idx     <= '0;
      r_en      <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_en      <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start && !abort) begin
          r_per_l <= w_per_clamp;
          r_num_l <= num_pulse;
          r_idx   <= '0;
          if (num_pulse == '0) begin
            r_timer <= C_ZERO;
            r_state <= S_TAIL;
          end else begin
            r_en    <= 1'b1;
            r_state <= S_FIRE;
          end
        end
      end else if (abort) begin
        // pulse_idx keeps the count reached so far.
        r_aborted <= 1'b1;
        r_state   <= S_IDLE;
      end else begin
        case (r_state)
          S_FIRE: begin
            r_idx <= w_idx_inc;
            if (w_idx_inc == r_num_l) begin
              r_timer <= C_MIN_GAP - C_ONE;
              r_state <= S_TAIL;
            end else begin
              r_timer <= r_per_l - C_ONE;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            // Timer parks at 1 once expired, so the next FIRE lands per_l cycles later.
            if (r_timer == C_ONE) begin
              if (w_trig_ok) begin
                r_en    <= 1'b1;
                r_state <= S_FIRE;
              end
            end else begin
              r_timer <= r_timer - C_ONE;
            end
          end
          S_TAIL: begin
            // done is registered, so it is raised while the timer moves 1->0.
            // The empty-burst path enters at 0 and raises it on exit instead.
            if (r_timer == C_ZERO) begin
              r_done  <= ~r_done;
              r_state <= S_IDLE;
            end else begin
              r_timer <= r_timer - C_ONE;
              if (r_timer == C_ONE) r_done <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign syn_md_out_en = r_en;
  assign pulse_idx     = r_idx;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_syn_md_sched.sv
// Directed testbench for syn_md_sched in the default build (timer-driven pulses).
module tb_syn_md_sched;

  logic        clkin;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] period;
  logic [7:0]  num_pulse;
  logic        syn_md_out_en;
  logic [7:0]  pulse_idx;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [1:0]  dbg_state;
`ifdef SYN_SCHED_EXT_TRIG_EN
  logic        ext_trig;
`endif

  int vectors;
  int miscompares;
  int cyc;

  logic [31:0] en_log[$];
  logic [31:0] done_log[$];
  logic [31:0] abort_log[$];
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  int          busy_cnt;
  int          busy_first;
  int          busy_last;

  syn_md_sched dut (
    .clkin         (clkin),
    .rst_n         (rst_n),
`ifdef SYN_SCHED_EXT_TRIG_EN
    .ext_trig      (ext_trig),
`endif
    .start         (start),
    .abort         (abort),
    .period        (period),
    .num_pulse     (num_pulse),
    .syn_md_out_en (syn_md_out_en),
    .pulse_idx     (pulse_idx),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .dbg_state     (dbg_state)
  );

  // Clock and cycle counter: cycle n is the interval after the n-th rising edge.
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;
  initial cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  always @(negedge clkin) begin
    if (syn_md_out_en) en_log.push_back(cyc);
    if (done)          done_log.push_back(cyc);
    if (aborted)       abort_log.push_back(cyc);
    if (busy) begin
      if (busy_cnt == 0) busy_first = cyc;
      busy_last = cyc;
      busy_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic clear_logs();
    en_log.delete();
    done_log.delete();
    abort_log.delete();
    busy_cnt   = 0;
    busy_first = -1;
    busy_last  = -1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compares act_q against exp_q: length first, then each entry.
  task automatic check_q(input string tag);
    check({tag, "_cnt"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), act_q[i], exp_q[i]);
  endtask

  // Starts a burst in the current cycle; returns that cycle index.
  task automatic launch(input logic [15:0] per, input logic [7:0] num, output int k);
    period    = per;
    num_pulse = num;
    start     = 1'b1;
    k         = cyc;
    tick(1);
    start     = 1'b0;
  endtask

  initial begin
    int k;
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    start     = 1'b1;
    abort     = 1'b0;
    period    = 16'd20;
    num_pulse = 8'd3;
`ifdef SYN_SCHED_EXT_TRIG_EN
    ext_trig  = 1'b0;
`endif
    clear_logs();

    // Reset with start held: nothing may fire, then 20 idle cycles.
    tick(3);
    start = 1'b0;
    rst_n = 1'b1;
    tick(20);
    check("rst_en_log",  en_log.size(), 0);
    check("rst_busy",    busy_cnt, 0);
    check("rst_done",    done_log.size(), 0);
    check("rst_abort",   abort_log.size(), 0);
    check("rst_idx",     pulse_idx, 0);
    check("rst_state",   dbg_state, 0);

    // Basic burst: period 20, 3 pulses; a start+config change mid-burst is ignored.
    clear_logs();
    launch(16'd20, 8'd3, k);
    tick(4);
    period = 16'd100; num_pulse = 8'd9; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(80);
    act_q = en_log;   exp_q = '{k+1, k+21, k+41}; check_q("b3_en");
    act_q = done_log; exp_q = '{k+58};            check_q("b3_done");
    check("b3_idx",        pulse_idx, 3);
    check("b3_busy_first", busy_first, k+1);
    check("b3_busy_last",  busy_last, k+58);
    check("b3_busy_cnt",   busy_cnt, 58);
    check("b3_abort",      abort_log.size(), 0);

    // Period below the stretcher window is clamped to 17.
    clear_logs();
    launch(16'd5, 8'd2, k);
    tick(60);
    act_q = en_log;   exp_q = '{k+1, k+18}; check_q("clamp_en");
    act_q = done_log; exp_q = '{k+35};      check_q("clamp_done");
    check("clamp_idx", pulse_idx, 2);

    // Empty burst: no pulse, one busy cycle, done two cycles after start.
    clear_logs();
    launch(16'd30, 8'd0, k);
    tick(10);
    check("n0_en",         en_log.size(), 0);
    act_q = done_log; exp_q = '{k+2}; check_q("n0_done");
    check("n0_busy_cnt",   busy_cnt, 1);
    check("n0_busy_first", busy_first, k+1);
    check("n0_idx",        pulse_idx, 0);

    // Abort 10 cycles after the second pulse, with a start in the same cycle.
    clear_logs();
    launch(16'd40, 8'd4, k);
    tick(50);
    abort = 1'b1; start = 1'b1; period = 16'd17; num_pulse = 8'd1;
    tick(1);
    abort = 1'b0; start = 1'b0;
    tick(100);
    act_q = en_log;    exp_q = '{k+1, k+41}; check_q("ab_en");
    act_q = abort_log; exp_q = '{k+52};      check_q("ab_abort");
    check("ab_done",      done_log.size(), 0);
    check("ab_idx",       pulse_idx, 2);
    check("ab_busy_last", busy_last, k+51);

    // Back-to-back: start held through done is taken on the first idle cycle.
    clear_logs();
    period = 16'd17; num_pulse = 8'd1; start = 1'b1;
    k = cyc;
    tick(20);
    start = 1'b0;
    tick(40);
    act_q = en_log;   exp_q = '{k+1, k+20};  check_q("b2b_en");
    act_q = done_log; exp_q = '{k+18, k+37}; check_q("b2b_done");

    // Reset mid-burst just before a pulse is due: that pulse is not issued.
    clear_logs();
    launch(16'd20, 8'd2, k);
    tick(19);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(30);
    act_q = en_log; exp_q = '{k+1}; check_q("mrst_en");
    check("mrst_done",  done_log.size(), 0);
    check("mrst_busy",  busy_last, k+20);
    check("mrst_idx",   pulse_idx, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
